// File: rtl/gate_deadtime_if.sv
// Gate-conditioning bus: raw switch commands and control in, conditioned drives and error status out.
interface gate_deadtime_if;
    logic       enable;
    logic       fault;
    logic [3:0] k_cmd;
    logic       err_clr;
    logic [3:0] k_out;
    logic [1:0] dead_act;
    logic       st_err;
    logic [7:0] err_cnt;

    modport master (
        output enable, fault, k_cmd, err_clr,
        input  k_out, dead_act, st_err, err_cnt
    );

    modport slave (
        input  enable, fault, k_cmd, err_clr,
        output k_out, dead_act, st_err, err_cnt
    );
endinterface

// File: rtl/gate_deadtime.sv
// Two-leg gate-drive conditioner: dead time, minimum on-pulse, shoot-through blocking,
// immediate all-off on fault/disable, and counting of illegal both-on command edges.
module gate_deadtime #(
    parameter int DT_CYC = 40,
    parameter int MIN_PW = 20,
    parameter int CNT_W  = 8
) (
    input logic          clk,
    input logic          rstn,
    gate_deadtime_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } leg_state_t;

    localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DT_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_PW);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic            kill;
    logic [1:0][1:0] leg_drive;
    logic [1:0]      leg_dead;
    logic [1:0]      leg_event;
    logic            st_err;
    logic [7:0]      err_cnt;
    logic [8:0]      err_sum;

    assign kill = bus.fault | ~bus.enable;

    for (genvar g = 0; g < 2; g++) begin : g_leg
        leg_state_t       state;
        leg_state_t       state_nxt;
        logic [CNT_W-1:0] dt_cnt;
        logic [CNT_W-1:0] dt_nxt;
        logic [CNT_W-1:0] on_cnt;
        logic [CNT_W-1:0] on_nxt;
        logic [1:0]       pair;
        logic             want_up;
        logic             want_dn;
        logic             illegal;
        logic             ill_prev;
        logic [1:0]       drive;
        logic             dead;

        // pair is {lower, upper}; 11 decodes to neither target, so the leg treats it as OFF
        assign pair    = bus.k_cmd[2*g +: 2];
        assign want_up = (pair == 2'b01);
        assign want_dn = (pair == 2'b10);
        assign illegal = &pair;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state    <= IDLE;
                dt_cnt   <= '0;
                on_cnt   <= '0;
                ill_prev <= 1'b0;
            end else begin
                state    <= state_nxt;
                dt_cnt   <= dt_nxt;
                on_cnt   <= on_nxt;
                ill_prev <= illegal;
            end
        end

        // DEAD never restarts on a target change; the target is only re-sampled as dt_cnt expires
        always_comb begin
            state_nxt = state;
            dt_nxt    = dt_cnt;
            on_nxt    = on_cnt;
            if (kill) begin
                state_nxt = IDLE;
                dt_nxt    = '0;
                on_nxt    = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (want_up || want_dn) begin
                            state_nxt = DEAD;
                            dt_nxt    = DT_LOAD;
                        end
                    end
                    DEAD: begin
                        if (dt_cnt == '0) begin
                            on_nxt = '0;
                            if (want_up) begin
                                state_nxt = HI;
                            end else if (want_dn) begin
                                state_nxt = LO;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            dt_nxt = dt_cnt - CNT_W'(1);
                        end
                    end
                    HI: begin
                        if (!want_up && (on_cnt >= MIN_LIM)) begin
                            state_nxt = DEAD;
                            dt_nxt    = DT_LOAD;
                            on_nxt    = '0;
                        end else if (on_cnt != CNT_MAX) begin
                            on_nxt = on_cnt + CNT_W'(1);
                        end
                    end
                    LO: begin
                        if (!want_dn && (on_cnt >= MIN_LIM)) begin
                            state_nxt = DEAD;
                            dt_nxt    = DT_LOAD;
                            on_nxt    = '0;
                        end else if (on_cnt != CNT_MAX) begin
                            on_nxt = on_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        dt_nxt    = '0;
                        on_nxt    = '0;
                    end
                endcase
            end
        end

        // Drives decode only the registered state, so one leg can never have both switches on
        always_comb begin
            drive = 2'b00;
            dead  = 1'b0;
            case (state)
                HI:      drive = 2'b01;
                LO:      drive = 2'b10;
                DEAD:    dead  = 1'b1;
                default: begin
                    drive = 2'b00;
                    dead  = 1'b0;
                end
            endcase
        end

        assign leg_drive[g] = drive;
        assign leg_dead[g]  = dead;
        assign leg_event[g] = illegal & ~ill_prev;
    end

    assign err_sum = {1'b0, err_cnt} + {8'd0, leg_event[0]} + {8'd0, leg_event[1]};

    // A clear in the same cycle as a new illegal edge wins and that edge is dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_err  <= 1'b0;
            err_cnt <= '0;
        end else if (bus.err_clr) begin
            st_err  <= 1'b0;
            err_cnt <= '0;
        end else if (|leg_event) begin
            st_err  <= 1'b1;
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign bus.k_out    = {leg_drive[1], leg_drive[0]};
    assign bus.dead_act = leg_dead;
    assign bus.st_err   = st_err;
    assign bus.err_cnt  = err_cnt;

endmodule

// File: tb/tb_gate_deadtime.sv
// Bench for gate_deadtime: directed vectors feed a cycle-stamped expectation queue drained by a
// negedge monitor, plus continuous shoot-through and dead-time invariant checks.
module tb_gate_deadtime;

    localparam int DT = 40;

    typedef struct {
        int         at;
        logic [3:0] k;
        logic [1:0] d;
        logic       se;
        logic [7:0] ec;
        string      name;
    } exp_t;

    logic           clk;
    logic           rstn;
    int             cyc;
    int             n_checks;
    int             n_fail;
    exp_t           sb_q[$];
    logic [1:0]     prev_pair[2];
    int             off_run[2];

    gate_deadtime_if bus_if();

    gate_deadtime #(
        .DT_CYC(40),
        .MIN_PW(20),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) sync();
    endtask

    task automatic apply_stimulus(input logic [3:0] k, input logic en, input logic flt, input logic clr);
        bus_if.k_cmd   = k;
        bus_if.enable  = en;
        bus_if.fault   = flt;
        bus_if.err_clr = clr;
    endtask

    task automatic expect_at(input int c, input logic [3:0] k, input logic [1:0] d,
                             input logic se, input logic [7:0] ec, input string name);
        exp_t e;
        e.at = c; e.k = k; e.d = d; e.se = se; e.ec = ec; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        n_checks++;
        if (bus_if.k_out !== e.k || bus_if.dead_act !== e.d ||
            bus_if.st_err !== e.se || bus_if.err_cnt !== e.ec) begin
            n_fail++;
            $display("[TB] FAIL %s @%0d: got k_out=%b dead_act=%b st_err=%b err_cnt=%0d, want k_out=%b dead_act=%b st_err=%b err_cnt=%0d",
                     e.name, cyc, bus_if.k_out, bus_if.dead_act, bus_if.st_err, bus_if.err_cnt,
                     e.k, e.d, e.se, e.ec);
        end
    endtask

    // Scoreboard monitor: pops every expectation due in this cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            if (sb_q[0].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL %s: due at %0d, reached %0d", sb_q[0].name, sb_q[0].at, cyc);
            end else begin
                check_output(sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
    end

    // Invariants: no leg both-on, and each switch turn-on follows at least DT both-off cycles
    initial begin
        prev_pair[0] = 2'b00; prev_pair[1] = 2'b00;
        off_run[0] = 0; off_run[1] = 0;
    end

    always @(negedge clk) begin
        if (rstn) begin
            for (int l = 0; l < 2; l++) begin
                logic [1:0] pair;
                pair = bus_if.k_out[2*l +: 2];
                n_checks++;
                if (pair == 2'b11) begin
                    n_fail++;
                    $display("[TB] FAIL shoot_through leg%0d @%0d: got %b, want not 11", l, cyc, pair);
                end
                if ((pair & ~prev_pair[l]) != 2'b00) begin
                    n_checks++;
                    if (off_run[l] < DT) begin
                        n_fail++;
                        $display("[TB] FAIL dead_time leg%0d @%0d: got %0d off cycles, want >= %0d",
                                 l, cyc, off_run[l], DT);
                    end
                end
                if (pair == 2'b00) off_run[l] = off_run[l] + 1;
                else               off_run[l] = 0;
                prev_pair[l] = pair;
            end
        end
    end

    initial begin
        int n;
        int m;
        int e;
        int guard;
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        sync(); sync();
        expect_at(cyc, 4'b0000, 2'b00, 1'b0, 8'd0, "reset");
        sync();
        rstn = 1'b1;
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        sync(); sync();

        // Leg A turn-on from IDLE
        n = cyc;
        apply_stimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        expect_at(n,      4'b0000, 2'b00, 1'b0, 8'd0, "t1_idle");
        expect_at(n + 1,  4'b0000, 2'b01, 1'b0, 8'd0, "t1_dead_start");
        expect_at(n + 40, 4'b0000, 2'b01, 1'b0, 8'd0, "t1_dead_end");
        expect_at(n + 41, 4'b0001, 2'b00, 1'b0, 8'd0, "t1_upper_on");
        wait_to(n + 141);

        // HI -> LO after a long on-time
        n = cyc;
        apply_stimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        expect_at(n,      4'b0001, 2'b00, 1'b0, 8'd0, "t2_still_hi");
        expect_at(n + 1,  4'b0000, 2'b01, 1'b0, 8'd0, "t2_upper_off");
        expect_at(n + 40, 4'b0000, 2'b01, 1'b0, 8'd0, "t2_dead_end");
        expect_at(n + 41, 4'b0010, 2'b00, 1'b0, 8'd0, "t2_lower_on");
        wait_to(n + 50);

        // Leg B short request: minimum pulse held, then DEAD back to IDLE
        n = cyc;
        m = n + 41;
        apply_stimulus(4'b0110, 1'b1, 1'b0, 1'b0);
        expect_at(n + 40, 4'b0010, 2'b10, 1'b0, 8'd0, "t3_b_dead");
        expect_at(m,      4'b0110, 2'b00, 1'b0, 8'd0, "t3_b_on");
        wait_to(m + 5);
        apply_stimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        expect_at(m + 20, 4'b0110, 2'b00, 1'b0, 8'd0, "t3_min_pw_hold");
        expect_at(m + 21, 4'b0010, 2'b10, 1'b0, 8'd0, "t3_b_off");
        expect_at(m + 60, 4'b0010, 2'b10, 1'b0, 8'd0, "t3_b_dead_end");
        expect_at(m + 61, 4'b0010, 2'b00, 1'b0, 8'd0, "t3_b_idle");
        wait_to(m + 70);

        // Illegal 11 commands, edge counting, clear priority, both legs at once
        n = cyc;
        apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b0);
        expect_at(n + 1, 4'b0000, 2'b01, 1'b1, 8'd1, "t4_first_illegal");
        wait_to(n + 10);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        expect_at(n + 11, 4'b0000, 2'b01, 1'b1, 8'd1, "t4_level_not_counted");
        expect_at(n + 12, 4'b0000, 2'b01, 1'b1, 8'd2, "t4_second_edge");
        wait_to(n + 11);
        apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b0);
        wait_to(n + 13);
        apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b1);
        expect_at(n + 14, 4'b0000, 2'b01, 1'b0, 8'd0, "t4_cleared");
        wait_to(n + 14);
        apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b0);
        wait_to(n + 15);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        wait_to(n + 16);
        apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b1);
        expect_at(n + 17, 4'b0000, 2'b01, 1'b0, 8'd0, "t4_clear_wins");
        wait_to(n + 17);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        wait_to(n + 18);
        apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        expect_at(n + 19, 4'b0000, 2'b01, 1'b1, 8'd2, "t4_both_legs");
        wait_to(n + 20);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b1);
        expect_at(n + 45, 4'b0000, 2'b00, 1'b0, 8'd0, "t4_all_idle");
        wait_to(n + 21);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        wait_to(n + 50);

        // Fault pulse with both legs HI, then enable drop
        n = cyc;
        apply_stimulus(4'b0101, 1'b1, 1'b0, 1'b0);
        expect_at(n + 41, 4'b0101, 2'b00, 1'b0, 8'd0, "t5_both_hi");
        wait_to(n + 45);
        apply_stimulus(4'b0101, 1'b1, 1'b1, 1'b0);
        expect_at(n + 45, 4'b0101, 2'b00, 1'b0, 8'd0, "t5_pre_fault");
        expect_at(n + 46, 4'b0000, 2'b00, 1'b0, 8'd0, "t5_fault_off");
        wait_to(n + 46);
        apply_stimulus(4'b0101, 1'b1, 1'b0, 1'b0);
        expect_at(n + 47, 4'b0000, 2'b11, 1'b0, 8'd0, "t5_restart_dead");
        expect_at(n + 86, 4'b0000, 2'b11, 1'b0, 8'd0, "t5_dead_end");
        expect_at(n + 87, 4'b0101, 2'b00, 1'b0, 8'd0, "t5_drives_back");
        wait_to(n + 90);
        apply_stimulus(4'b0101, 1'b0, 1'b0, 1'b0);
        expect_at(n + 91, 4'b0000, 2'b00, 1'b0, 8'd0, "t5_disable_off");
        wait_to(n + 92);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        wait_to(n + 95);

        // err_cnt saturation: two events per 1111 edge
        for (int i = 0; i < 130; i++) begin
            apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b0);
            e = (i + 1) * 2;
            if (e > 255) e = 255;
            if (i >= 125) expect_at(cyc + 1, 4'b0000, 2'b00, 1'b1, 8'(e), "sat_count");
            sync();
            apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
            sync();
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b1);
        sync();
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);

        // Random commands with occasional fault/disable, invariants only
        repeat (300) begin
            apply_stimulus(4'($urandom), ($urandom_range(0, 19) != 0),
                           ($urandom_range(0, 29) == 0), ($urandom_range(0, 31) == 0));
            sync();
            bus_if.fault   = 1'b0;
            bus_if.err_clr = 1'b0;
            repeat ($urandom_range(1, 60)) sync();
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);

        guard = 0;
        while (sb_q.size() > 0 && guard < 500) begin
            sync();
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
